// File: rtl/shifter_pipe_if.sv
// ---------------------------------------------------------------------------
// shifter_pipe_if
//   Bundles the upstream (operand) and downstream (result) valid/ready
//   channels of shifter_pipe.
//
//   Handshake rule for both channels: a transfer happens on a rising clock
//   edge where valid and ready are both high. The sender keeps valid and its
//   data stable until that transfer. ready may depend on the receiver's state
//   and on the downstream ready, but never on valid.
//
//   Signals
//     in_valid   upstream presents an operation
//     in_ready   pipe accepts the operation this cycle
//     In_A       operand
//     Cnt        shift amount 0..2**CNT_W-1
//     Op         00 rotl, 01 shl, 10 rotr, 11 shr
//     out_valid  Out holds a completed result
//     out_ready  downstream consumes Out this cycle
//     Out        result
//   Modports
//     master  drives the operation and consumes the result (upstream/downstream side)
//     slave   the shifter pipe itself
// ---------------------------------------------------------------------------
interface shifter_pipe_if #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] In_A;
   logic [CNT_W-1:0] Cnt;
   logic [1:0]       Op;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] Out;

   modport master (
      output in_valid, In_A, Cnt, Op, out_ready,
      input  in_ready, out_valid, Out
   );

   modport slave (
      input  in_valid, In_A, Cnt, Op, out_ready,
      output in_ready, out_valid, Out
   );
endinterface

// File: rtl/shifter_pipe.sv
// ---------------------------------------------------------------------------
// shifter_pipe
//   Two-stage pipelined 16-bit shifter/rotator built from a 1/2/4/8
//   mux-stage chain.
//     S1 register: result after the shift-by-1 and shift-by-2 stages,
//                  plus the upper count bits and the op code.
//     S2 register: result after the shift-by-4 and shift-by-8 stages,
//                  already un-reversed for right ops. Drives Out directly.
//   Right ops are done with the left chain: the operand is bit-reversed on
//   entry and the final result bit-reversed on exit.
//
//   Ports
//     clk    rising-edge clock
//     rst    asynchronous active-high reset
//     flush  synchronous; kills everything in flight, drops this cycle's input
//     bus    shifter_pipe_if slave modport (operand in, result out)
//
//   WIDTH must be 16 and CNT_W must be 4: the four mux stages are fixed.
// ---------------------------------------------------------------------------
module shifter_pipe #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          flush,
   shifter_pipe_if.slave bus
);

   // ------------------------------------------------------------------------
   // Helpers
   // ------------------------------------------------------------------------
   function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
      logic [WIDTH-1:0] r;
      for (int i = 0; i < WIDTH; i++) begin
         r[i] = x[WIDTH-1-i];
      end
      return r;
   endfunction

   // ------------------------------------------------------------------------
   // Pipeline registers
   // ------------------------------------------------------------------------
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_data_q,  s1_data_d;
   logic [1:0]       s1_cnt_hi_q, s1_cnt_hi_d;   // Cnt[3:2], consumed by stage 2
   logic [1:0]       s1_op_q,    s1_op_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_data_q,  s2_data_d;

   // ------------------------------------------------------------------------
   // Handshake
   // ------------------------------------------------------------------------
   logic adv1;
   logic adv2;
   logic accept;

   // A stage may take new contents when it is empty or its contents leave.
   assign adv2   = ~s2_valid_q | bus.out_ready;
   assign adv1   = ~s1_valid_q | adv2;
   // flush beats accept: the operation offered in a flush cycle is dropped.
   assign accept = bus.in_valid & adv1 & ~flush;

   // ------------------------------------------------------------------------
   // Stage 1 datapath: entry reversal, shift-by-1, shift-by-2
   // ------------------------------------------------------------------------
   logic [CNT_W-1:0] cnt_in;
   logic             rot_in;
   logic [WIDTH-1:0] st_in;
   logic [WIDTH-1:0] st_1;
   logic [WIDTH-1:0] st_2;

   assign cnt_in = bus.Cnt;
   // Op[0]=0 means rotate: vacated bits take the bits shifted out at the top.
   assign rot_in = ~bus.Op[0];

   always_comb begin
      st_in = bus.Op[1] ? bit_rev(bus.In_A) : bus.In_A;

      st_1 = st_in;
      if (cnt_in[0]) begin
         st_1 = {st_in[WIDTH-2:0], rot_in & st_in[WIDTH-1]};
      end

      st_2 = st_1;
      if (cnt_in[1]) begin
         st_2 = {st_1[WIDTH-3:0], (rot_in ? st_1[WIDTH-1:WIDTH-2] : 2'b00)};
      end
   end

   // ------------------------------------------------------------------------
   // Stage 2 datapath: shift-by-4, shift-by-8, exit reversal
   // ------------------------------------------------------------------------
   logic             rot_s1;
   logic [WIDTH-1:0] st_4;
   logic [WIDTH-1:0] st_8;
   logic [WIDTH-1:0] st_out;

   assign rot_s1 = ~s1_op_q[0];

   always_comb begin
      st_4 = s1_data_q;
      if (s1_cnt_hi_q[0]) begin
         st_4 = {s1_data_q[WIDTH-5:0], (rot_s1 ? s1_data_q[WIDTH-1:WIDTH-4] : 4'h0)};
      end

      st_8 = st_4;
      if (s1_cnt_hi_q[1]) begin
         st_8 = {st_4[WIDTH-9:0], (rot_s1 ? st_4[WIDTH-1:WIDTH-8] : 8'h00)};
      end

      st_out = s1_op_q[1] ? bit_rev(st_8) : st_8;
   end

   // ------------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      s1_valid_d  = s1_valid_q;
      s1_data_d   = s1_data_q;
      s1_cnt_hi_d = s1_cnt_hi_q;
      s1_op_d     = s1_op_q;
      s2_valid_d  = s2_valid_q;
      s2_data_d   = s2_data_q;

      if (flush) begin
         // Data registers keep whatever they hold; only the valid bits matter.
         s1_valid_d = 1'b0;
         s2_valid_d = 1'b0;
      end else begin
         if (adv1) begin
            s1_valid_d = accept;
            if (accept) begin
               s1_data_d   = st_2;
               s1_cnt_hi_d = cnt_in[CNT_W-1:CNT_W-2];
               s1_op_d     = bus.Op;
            end
         end

         if (adv2) begin
            s2_valid_d = s1_valid_q;
            // Bubbles leave S2 data untouched so Out only moves on real results.
            if (s1_valid_q) begin
               s2_data_d = st_out;
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q  <= 1'b0;
         s1_data_q   <= '0;
         s1_cnt_hi_q <= 2'b00;
         s1_op_q     <= 2'b00;
         s2_valid_q  <= 1'b0;
         s2_data_q   <= '0;
      end else begin
         s1_valid_q  <= s1_valid_d;
         s1_data_q   <= s1_data_d;
         s1_cnt_hi_q <= s1_cnt_hi_d;
         s1_op_q     <= s1_op_d;
         s2_valid_q  <= s2_valid_d;
         s2_data_q   <= s2_data_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs: Out is purely registered, no path from In_A.
   // ------------------------------------------------------------------------
   assign bus.in_ready  = adv1;
   assign bus.out_valid = s2_valid_q;
   assign bus.Out       = s2_data_q;

endmodule

// File: tb/tb_shifter_pipe.sv
// ---------------------------------------------------------------------------
// tb_shifter_pipe
//   Bench for shifter_pipe. Inputs change 1 ns after the falling edge;
//   the monitor samples 1 ns before the rising edge. The reference model is
//   an arithmetic shift/rotate function plus a queue of results that are
//   inside the pipe (accepted, not yet consumed).
// ---------------------------------------------------------------------------
module tb_shifter_pipe;

   logic clk = 1'b0;
   logic rst;
   logic flush;

   shifter_pipe_if bus_if ();

   shifter_pipe dut (
      .clk   (clk),
      .rst   (rst),
      .flush (flush),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int          n_vec  = 0;
   int          n_fail = 0;
   logic [15:0] exp_q[$];

   // ------------------------------------------------------------------------
   // Reference model: plain arithmetic on a 32-bit copy of the operand.
   // ------------------------------------------------------------------------
   function automatic logic [15:0] ref_shift(input logic [15:0] a,
                                             input logic [3:0]  c,
                                             input logic [1:0]  o);
      logic [31:0] x;
      logic [31:0] r;
      int unsigned n;
      x = {16'h0000, a};
      n = int'(c);
      case (o)
         2'b00:   r = (x << n) | (x >> (16 - n));
         2'b01:   r = x << n;
         2'b10:   r = (x >> n) | (x << (16 - n));
         default: r = x >> n;
      endcase
      return r[15:0];
   endfunction

   task automatic chk1(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Driver
   // ------------------------------------------------------------------------
   task automatic drive(input logic v, input logic [15:0] a, input logic [3:0] c,
                        input logic [1:0] o, input logic ordy, input logic fl);
      @(negedge clk);
      #1;
      bus_if.in_valid  = v;
      bus_if.In_A      = a;
      bus_if.Cnt       = c;
      bus_if.Op        = o;
      bus_if.out_ready = ordy;
      flush            = fl;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 16'h0000, 4'h0, 2'b00, 1'b1, 1'b0);
   endtask

   // Single op into an empty pipe; checks latency and the literal result.
   task automatic run_one(input logic [15:0] a, input logic [3:0] c, input logic [1:0] o,
                          input logic [15:0] exp, input string name);
      drive(1'b1, a, c, o, 1'b1, 1'b0);
      drive(1'b0, a, c, o, 1'b1, 1'b0);
      #1;
      chk1({name, "_lat1"}, bus_if.out_valid, 1'b0);
      @(negedge clk);
      #2;
      chk1({name, "_valid"}, bus_if.out_valid, 1'b1);
      chk16(name, bus_if.Out, exp);
   endtask

   task automatic wait_empty(input string name);
      bit done;
      done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         drive(1'b0, 16'h0000, 4'h0, 2'b00, 1'b1, 1'b0);
         #1;
         if (exp_q.size() == 0 && !bus_if.out_valid) done = 1'b1;
      end
      n_vec++;
      if (!done) begin
         n_fail++;
         $display("FAIL %s: pipe still holds %0d results after drain budget", name, exp_q.size());
      end
   endtask

   // ------------------------------------------------------------------------
   // Monitor / scoreboard
   // ------------------------------------------------------------------------
   logic        prev_stall = 1'b0;
   logic [15:0] prev_out   = 16'h0000;

   initial begin
      forever begin
         @(negedge clk);
         #4;
         if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
         end else begin
            if (prev_stall) begin
               chk1("hold_valid", bus_if.out_valid, 1'b1);
               chk16("hold_data", bus_if.Out, prev_out);
            end
            chk1("in_ready", bus_if.in_ready, (exp_q.size() < 2) || bus_if.out_ready);
            if (exp_q.size() == 0) chk1("no_phantom", bus_if.out_valid, 1'b0);
            if (exp_q.size() == 2) chk1("full_valid", bus_if.out_valid, 1'b1);
            if (bus_if.out_valid && bus_if.out_ready && exp_q.size() > 0) begin
               chk16("result", bus_if.Out, exp_q.pop_front());
            end
            prev_stall = bus_if.out_valid & ~bus_if.out_ready & ~flush;
            prev_out   = bus_if.Out;
            if (flush) begin
               exp_q.delete();
            end else if (bus_if.in_valid && bus_if.in_ready) begin
               exp_q.push_back(ref_shift(bus_if.In_A, bus_if.Cnt, bus_if.Op));
            end
         end
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   logic [15:0] bp_a[4] = '{16'h1234, 16'hF00F, 16'h8000, 16'hABCD};
   logic [3:0]  bp_c[4] = '{4'd4,     4'd3,     4'd15,    4'd8};
   logic [1:0]  bp_o[4] = '{2'b00,    2'b01,    2'b11,    2'b10};

   initial begin
      int idx;
      rst              = 1'b1;
      flush            = 1'b0;
      bus_if.in_valid  = 1'b0;
      bus_if.In_A      = 16'h0000;
      bus_if.Cnt       = 4'h0;
      bus_if.Op        = 2'b00;
      bus_if.out_ready = 1'b0;
      #1;
      chk1("rst_out_valid", bus_if.out_valid, 1'b0);
      chk16("rst_out", bus_if.Out, 16'h0000);
      repeat (3) @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk1("rst_in_ready", bus_if.in_ready, 1'b1);

      // Directed ops on 16'h8001
      run_one(16'h8001, 4'd1, 2'b00, 16'h0003, "rotl1");
      run_one(16'h8001, 4'd1, 2'b01, 16'h0002, "shl1");
      run_one(16'h8001, 4'd1, 2'b10, 16'hC000, "rotr1");
      run_one(16'h8001, 4'd1, 2'b11, 16'h4000, "shr1");

      // Count boundaries
      run_one(16'hA5C3, 4'd0, 2'b00, 16'hA5C3, "cnt0_rotl");
      run_one(16'hA5C3, 4'd0, 2'b01, 16'hA5C3, "cnt0_shl");
      run_one(16'hA5C3, 4'd0, 2'b10, 16'hA5C3, "cnt0_rotr");
      run_one(16'hA5C3, 4'd0, 2'b11, 16'hA5C3, "cnt0_shr");
      run_one(16'h0001, 4'd15, 2'b00, 16'h8000, "cnt15_rotl");
      run_one(16'h0001, 4'd1,  2'b10, 16'h8000, "rotr1_eq_rotl15");
      run_one(16'h0001, 4'd15, 2'b11, 16'h0000, "cnt15_shr");
      idle(2);

      // Backpressure: out_ready low, offer 4 ops, only 2 may enter
      idx = 0;
      for (int cyc = 0; cyc < 6; cyc++) begin
         drive(idx < 4, bp_a[idx % 4], bp_c[idx % 4], bp_o[idx % 4], 1'b0, 1'b0);
         #2;
         if (bus_if.in_ready && idx < 4) idx++;
      end
      chk16("bp_accepts", 16'(idx), 16'd2);
      chk1("bp_in_ready", bus_if.in_ready, 1'b0);
      chk1("bp_out_valid", bus_if.out_valid, 1'b1);
      chk16("bp_out_op0", bus_if.Out, 16'h2341);
      for (int cyc = 0; cyc < 10 && idx < 4; cyc++) begin
         drive(1'b1, bp_a[idx], bp_c[idx], bp_o[idx], 1'b1, 1'b0);
         #2;
         if (bus_if.in_ready) idx++;
      end
      chk16("bp_all_accepted", 16'(idx), 16'd4);
      wait_empty("bp_drain");

      // Flush with two ops in flight; the op offered during flush is dropped
      drive(1'b1, 16'h1111, 4'd1, 2'b00, 1'b1, 1'b0);
      drive(1'b1, 16'h2222, 4'd2, 2'b01, 1'b1, 1'b0);
      drive(1'b1, 16'h3333, 4'd3, 2'b10, 1'b1, 1'b1);
      drive(1'b0, 16'h0000, 4'd0, 2'b00, 1'b1, 1'b0);
      #1;
      chk1("flush_kill", bus_if.out_valid, 1'b0);
      idle(2);
      chk1("flush_no_late", bus_if.out_valid, 1'b0);
      run_one(16'h00F0, 4'd4, 2'b11, 16'h000F, "post_flush");
      idle(2);

      // Reset with ops in flight
      drive(1'b1, 16'h0F0F, 4'd2, 2'b00, 1'b0, 1'b0);
      drive(1'b1, 16'hF0F0, 4'd5, 2'b01, 1'b0, 1'b0);
      drive(1'b0, 16'h0000, 4'd0, 2'b00, 1'b0, 1'b0);
      #1;
      chk1("pre_rst_valid", bus_if.out_valid, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk1("midrst_out_valid", bus_if.out_valid, 1'b0);
      chk16("midrst_out", bus_if.Out, 16'h0000);
      @(negedge clk);
      #1;
      rst = 1'b0;
      #1;
      chk1("midrst_in_ready", bus_if.in_ready, 1'b1);
      idle(2);
      chk1("midrst_no_pulse", bus_if.out_valid, 1'b0);

      // Random traffic
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 9) < 7, 16'($urandom), 4'($urandom), 2'($urandom),
               $urandom_range(0, 9) < 6, $urandom_range(0, 199) == 0);
      end
      wait_empty("rand_drain");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
